uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Round-robin scheduler that shares one UART transmitter among NREQ byte producers
//  (e.g. cipher-output, status, debug).
//  - Accepts one byte at a time per requester via a valid/ready handshake.
//  - Latches the byte, drives the transmitter's enable/message/word-length inputs, and
//    tracks its done flag through a complete frame before granting the next requester.
//  - A watchdog recovers from a transmitter that never signals done.
// PARAMETERS
//  NREQ       4        number of requesters (2..8)
//  EN_HOLD    4        Clock cycles uart_tx_en is held high per frame (>=2, edge-detected downstream)
//  TIMEOUT    1048575  Clock cycles allowed in WAIT_DONE+WAIT_CLR before abort
//  TO_W       20       width of timeout counter (must hold TIMEOUT)
// PORTS
//  Clock         in   1        system clock
//  Reset         in   1        asynchronous, active-high reset
//  req_valid     in   NREQ     requester i has a byte pending
//  req_data      in   8*NREQ   byte of requester i at [8*i+7:8*i]
//  req_ready     out  NREQ     one-cycle pulse: byte of requester i accepted this cycle
//  cfg_nbits     in   4        data bits per frame, sampled at grant
//  uart_tx_en    out  1        enable pulse to transmitter
//  uart_message  out  8        byte to transmitter, stable from grant to frame end
//  uart_nbits    out  4        word length to transmitter, stable with uart_message
//  uart_tx_done  in   1        transmitter done flag (tick domain, 2-flop synchronised here)
//  busy          out  1        high in any state other than IDLE
//  grant_id      out  3        index of requester owning current frame
//  timeout_err   out  1        one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset values: all outputs 0, rr pointer 0, state IDLE, timeout counter 0, done-sync flops 0.
//  FSM states: IDLE, START, WAIT_DONE, WAIT_CLR.
//  IDLE:
//   - If any req_valid is set, pick the first set bit scanning ptr, ptr+1 .. (mod NREQ).
//   - Same cycle: pulse req_ready[i]; on the next edge latch uart_message, uart_nbits,
//     grant_id=i, ptr=(i+1) mod NREQ; go to START.
//   - Selection and handshake complete in one cycle; req_valid may drop immediately after.
//  START:
//   - uart_tx_en=1 for exactly EN_HOLD cycles, then 0; go to WAIT_DONE.
//  WAIT_DONE:
//   - Wait for synchronised done=1, then go to WAIT_CLR.
//  WAIT_CLR:
//   - Wait for synchronised done=0 (transmitter back in its idle state), then go to IDLE.
//   - The next grant is possible on the cycle after returning to IDLE.
//  Word-length rules:
//   - cfg_nbits of 0 or >8 is clamped to 8.
//   - cfg_nbits changes after grant do not affect the frame in flight.
//  Watchdog:
//   - Counter clears on entry to WAIT_DONE and counts in WAIT_DONE/WAIT_CLR.
//   - At TIMEOUT-1: pulse timeout_err, go to IDLE, leave ptr as already advanced.
//   - The timed-out byte is dropped, not retried.
//  Edge cases:
//   - req_ready is never asserted outside IDLE; at most one bit is high per cycle.
//   - A requester re-asserting while its own frame is in flight waits for its next rr turn.
//   - Done already high in IDLE (stale) is ignored; only WAIT_DONE samples it.
//   - Reset mid-frame aborts immediately: uart_tx_en drops to 0, the latched byte is lost,
//     and no req_ready pulse is issued.
// TESTING
//  1. Single req: req_valid=0001, data[7:0]=8'hA5, cfg_nbits=8 -> req_ready=0001 for 1 cycle,
//     uart_message=A5, uart_tx_en high 4 cycles, grant_id=0.
//  2. Round robin: all four valid continuously (bytes 11,22,33,44) -> grant order 0,1,2,3,0;
//     each grant only after done rises then falls.
//  3. Clamp: cfg_nbits=0 and 4'hC -> uart_nbits=8; cfg_nbits=7 -> 7; cfg_nbits changed
//     mid-frame -> uart_nbits unchanged.
//  4. Timeout (TIMEOUT=64): uart_tx_done held 0 -> timeout_err pulses 64 cycles after
//     WAIT_DONE entry, busy falls, next requester granted.
//  5. Reset mid-frame: assert Reset during START -> uart_tx_en, busy, req_ready all 0
//     immediately; after release req 2 alone -> grant_id=2 (ptr back at 0).
//  6. Stale done: uart_tx_done=1 while IDLE, then req 1 -> FSM waits for done fall then rise;
//     no early return to IDLE.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Grants one byte per frame, pulses the transmitter enable, and follows its done flag.
module uart_tx_scheduler #(
    parameter int NREQ    = 4,
    parameter int EN_HOLD = 4,
    parameter int TIMEOUT = 1048575,
    parameter int TO_W    = 20
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3:0]        cfg_nbits,
    output logic              uart_tx_en,
    output logic [7:0]        uart_message,
    output logic [3:0]        uart_nbits,
    input  logic              uart_tx_done,
    output logic              busy,
    output logic [2:0]        grant_id,
    output logic              timeout_err
);
    localparam int EW = $clog2(EN_HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_WAIT_CLR} state_t;

    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d;
    logic [2:0]      grant_id_q, grant_id_d;
    logic [7:0]      msg_q, msg_d;
    logic [3:0]      nbits_q, nbits_d;
    logic            tx_en_q, tx_en_d;
    logic            timeout_err_q, timeout_err_d;
    logic            armed_q, armed_d;
    logic [EW-1:0]   en_cnt_q, en_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            done_s1_q, done_s2_q;

    // Requester bytes and valids padded to 8 entries so a 3-bit index is always in range
    logic [7:0] req_byte [8];
    logic [7:0] valid_pad;
    assign valid_pad = 8'(req_valid);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            if (gi < NREQ) begin : g_used
                assign req_byte[gi] = req_data[8*gi +: 8];
            end else begin : g_pad
                assign req_byte[gi] = 8'h00;
            end
        end
    endgenerate

    logic       sel_found;
    logic [2:0] sel_idx;
    logic [3:0] cand;

    // Descending scan so the candidate closest to ptr wins
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        cand      = 4'd0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            if (valid_pad[cand[2:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[2:0];
            end
        end
    end

    logic       grant_now;
    logic [3:0] nbits_clamped;

    assign grant_now     = (state_q == S_IDLE) && sel_found && !Reset;
    assign nbits_clamped = (cfg_nbits == 4'd0 || cfg_nbits > 4'd8) ? 4'd8 : cfg_nbits;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_now && (sel_idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_id_d    = grant_id_q;
        msg_d         = msg_q;
        nbits_d       = nbits_q;
        tx_en_d       = tx_en_q;
        timeout_err_d = 1'b0;
        armed_d       = armed_q;
        en_cnt_d      = en_cnt_q;
        to_cnt_d      = to_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_now) begin
                    state_d    = S_START;
                    ptr_d      = (sel_idx == 3'(NREQ - 1)) ? 3'd0 : sel_idx + 3'd1;
                    grant_id_d = sel_idx;
                    msg_d      = req_byte[sel_idx];
                    nbits_d    = nbits_clamped;
                    tx_en_d    = 1'b1;
                    en_cnt_d   = '0;
                    armed_d    = 1'b0;
                end
            end
            S_START: begin
                // A done level left over from a previous frame must fall before a rise counts
                if (!done_s2_q) begin
                    armed_d = 1'b1;
                end
                if (en_cnt_q == EW'(EN_HOLD - 1)) begin
                    tx_en_d  = 1'b0;
                    state_d  = S_WAIT_DONE;
                    to_cnt_d = '0;
                end else begin
                    en_cnt_d = en_cnt_q + EW'(1);
                end
            end
            S_WAIT_DONE: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (!done_s2_q) begin
                    armed_d = 1'b1;
                end
                if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (done_s2_q && armed_q) begin
                    state_d = S_WAIT_CLR;
                end
            end
            S_WAIT_CLR: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (!done_s2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            ptr_q         <= 3'd0;
            grant_id_q    <= 3'd0;
            msg_q         <= 8'h00;
            nbits_q       <= 4'd0;
            tx_en_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            armed_q       <= 1'b0;
            en_cnt_q      <= '0;
            to_cnt_q      <= '0;
            done_s1_q     <= 1'b0;
            done_s2_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_id_q    <= grant_id_d;
            msg_q         <= msg_d;
            nbits_q       <= nbits_d;
            tx_en_q       <= tx_en_d;
            timeout_err_q <= timeout_err_d;
            armed_q       <= armed_d;
            en_cnt_q      <= en_cnt_d;
            to_cnt_q      <= to_cnt_d;
            done_s1_q     <= uart_tx_done;
            done_s2_q     <= done_s1_q;
        end
    end

    assign uart_tx_en   = tx_en_q;
    assign uart_message = msg_q;
    assign uart_nbits   = nbits_q;
    assign grant_id     = grant_id_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (NREQ=4, EN_HOLD=4, TIMEOUT=64).
module tb_uart_tx_scheduler;
    localparam int NREQ    = 4;
    localparam int EN_HOLD = 4;
    localparam int TIMEOUT = 64;
    localparam int TO_W    = 8;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic [3:0]        cfg_nbits = 4'd8;
    logic              uart_tx_en;
    logic [7:0]        uart_message;
    logic [3:0]        uart_nbits;
    logic              uart_tx_done = 1'b0;
    logic              busy;
    logic [2:0]        grant_id;
    logic              timeout_err;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    uart_tx_scheduler #(
        .NREQ(NREQ), .EN_HOLD(EN_HOLD), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .Clock(Clock), .Reset(Reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cfg_nbits(cfg_nbits), .uart_tx_en(uart_tx_en),
        .uart_message(uart_message), .uart_nbits(uart_nbits), .uart_tx_done(uart_tx_done),
        .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1; req_valid = '0; req_data = '0; uart_tx_done = 1'b0; cfg_nbits = 4'd8;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
    endtask

    // Called right after driving at a negedge; returns cycles until req_ready is seen
    task automatic wait_ready(output int cyc);
        cyc = -1;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (req_ready != '0) begin
                cyc = c;
                break;
            end
            @(negedge Clock);
        end
    endtask

    task automatic wait_en_fall(output int hi);
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            if (!uart_tx_en) break;
            hi++;
            @(negedge Clock);
        end
    endtask

    // Drives a done rise then fall; lat = cycles from fall until busy drops
    task automatic finish_frame(output bit early, output int lat);
        early = 1'b0;
        uart_tx_done = 1'b1;
        repeat (4) begin
            @(negedge Clock);
            if (!busy || req_ready != '0) early = 1'b1;
        end
        uart_tx_done = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge Clock);
            if (!busy) begin
                lat = c;
                break;
            end
            if (req_ready != '0) early = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge Clock);
        Reset = 1'b1; req_valid = 4'b1111; req_data = 32'h44332211;
        #1;
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        tests++; if (uart_tx_en !== 1'b0) begin fails++; $display("FAIL reset_tx_en got %b want 0", uart_tx_en); end
        tests++; if (uart_message !== 8'h00) begin fails++; $display("FAIL reset_msg got %h want 00", uart_message); end
        tests++; if (uart_nbits !== 4'd0) begin fails++; $display("FAIL reset_nbits got %0d want 0", uart_nbits); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (grant_id !== 3'd0) begin fails++; $display("FAIL reset_grant got %0d want 0", grant_id); end
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
        $display("[TB] reset: outputs sampled");
        do_reset();
    endtask

    task automatic test_single();
        int cyc, hi, lat;
        bit early;
        do_reset();
        @(negedge Clock);
        req_data[7:0] = 8'hA5; cfg_nbits = 4'd8; req_valid = 4'b0001;
        wait_ready(cyc);
        tests++; if (cyc !== 0) begin fails++; $display("FAIL single_ready_lat got %0d want 0", cyc); end
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_ready got %b want 0001", req_ready); end
        @(negedge Clock);
        req_valid = '0;
        #1;
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL single_ready_pulse got %b want 0000", req_ready); end
        tests++; if (uart_message !== 8'hA5) begin fails++; $display("FAIL single_msg got %h want a5", uart_message); end
        tests++; if (uart_nbits !== 4'd8) begin fails++; $display("FAIL single_nbits got %0d want 8", uart_nbits); end
        tests++; if (grant_id !== 3'd0) begin fails++; $display("FAIL single_grant got %0d want 0", grant_id); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy got %b want 1", busy); end
        wait_en_fall(hi);
        tests++; if (hi !== EN_HOLD) begin fails++; $display("FAIL single_en_hold got %0d want %0d", hi, EN_HOLD); end
        finish_frame(early, lat);
        tests++; if (early !== 1'b0) begin fails++; $display("FAIL single_early got %b want 0", early); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL single_idle_lat got %0d want 3", lat); end
        $display("[TB] single: grant %0d byte %h en_cycles %0d", grant_id, uart_message, hi);
    endtask

    task automatic test_round_robin();
        int cyc, hi, lat, exp;
        bit early;
        logic [7:0] bytes [4];
        logic [NREQ-1:0] exp_rdy;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        do_reset();
        @(negedge Clock);
        req_data = 32'h44332211; req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = k % 4;
            exp_rdy = 4'b0001 << exp;
            wait_ready(cyc);
            tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rr_ready[%0d] got %b want %b", k, req_ready, exp_rdy); end
            @(negedge Clock);
            #1;
            tests++; if (grant_id !== 3'(exp)) begin fails++; $display("FAIL rr_grant[%0d] got %0d want %0d", k, grant_id, exp); end
            tests++; if (uart_message !== bytes[exp]) begin fails++; $display("FAIL rr_msg[%0d] got %h want %h", k, uart_message, bytes[exp]); end
            wait_en_fall(hi);
            finish_frame(early, lat);
            tests++; if (early !== 1'b0) begin fails++; $display("FAIL rr_early[%0d] got %b want 0", k, early); end
            tests++; if (lat !== 3) begin fails++; $display("FAIL rr_idle_lat[%0d] got %0d want 3", k, lat); end
            $display("[TB] rr: frame %0d grant %0d byte %h", k, grant_id, uart_message);
        end
        req_valid = '0;
    endtask

    task automatic test_clamp();
        int cyc, hi, lat;
        bit early;
        logic [3:0] cfg_tab [4];
        logic [3:0] mid_tab [4];
        logic [3:0] exp_tab [4];
        cfg_tab[0] = 4'd0;  exp_tab[0] = 4'd8; mid_tab[0] = 4'd5;
        cfg_tab[1] = 4'hC;  exp_tab[1] = 4'd8; mid_tab[1] = 4'd3;
        cfg_tab[2] = 4'd7;  exp_tab[2] = 4'd7; mid_tab[2] = 4'd9;
        cfg_tab[3] = 4'd1;  exp_tab[3] = 4'd1; mid_tab[3] = 4'd8;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            req_data[7:0] = 8'h30 + 8'(i); cfg_nbits = cfg_tab[i]; req_valid = 4'b0001;
            wait_ready(cyc);
            @(negedge Clock);
            req_valid = '0; cfg_nbits = mid_tab[i];
            #1;
            tests++; if (uart_nbits !== exp_tab[i]) begin fails++; $display("FAIL clamp_nbits[%0d] got %0d want %0d", i, uart_nbits, exp_tab[i]); end
            wait_en_fall(hi);
            tests++; if (uart_nbits !== exp_tab[i]) begin fails++; $display("FAIL clamp_hold[%0d] got %0d want %0d", i, uart_nbits, exp_tab[i]); end
            finish_frame(early, lat);
            $display("[TB] clamp: cfg %0d -> nbits %0d", cfg_tab[i], uart_nbits);
        end
    endtask

    task automatic test_timeout();
        int cyc, hi, to_at;
        do_reset();
        @(negedge Clock);
        req_data = 32'h00006655; req_valid = 4'b0011;
        wait_ready(cyc);
        tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL to_first_ready got %b want 0001", req_ready); end
        @(negedge Clock);
        wait_en_fall(hi);
        to_at = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge Clock);
            if (timeout_err) begin
                to_at = c;
                break;
            end
        end
        tests++; if (to_at !== TIMEOUT) begin fails++; $display("FAIL to_cycle got %0d want %0d", to_at, TIMEOUT); end
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL to_busy got %b want 0", busy); end
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL to_next_ready got %b want 0010", req_ready); end
        @(negedge Clock);
        #1;
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_pulse got %b want 0", timeout_err); end
        tests++; if (grant_id !== 3'd1) begin fails++; $display("FAIL to_grant got %0d want 1", grant_id); end
        tests++; if (uart_message !== 8'h66) begin fails++; $display("FAIL to_msg got %h want 66", uart_message); end
        req_valid = '0;
        $display("[TB] timeout: abort after %0d cycles, next grant %0d", to_at, grant_id);
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset();
        @(negedge Clock);
        req_data[7:0] = 8'hE1; req_valid = 4'b0001;
        wait_ready(cyc);
        @(negedge Clock);
        req_valid = '0;
        @(negedge Clock);
        Reset = 1'b1; req_valid = 4'b0100; req_data[23:16] = 8'h77;
        #1;
        tests++; if (uart_tx_en !== 1'b0) begin fails++; $display("FAIL rst_mid_en got %b want 0", uart_tx_en); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rst_mid_ready got %b want 0000", req_ready); end
        tests++; if (uart_message !== 8'h00) begin fails++; $display("FAIL rst_mid_msg got %h want 00", uart_message); end
        @(negedge Clock);
        Reset = 1'b0;
        wait_ready(cyc);
        tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL rst_mid_ready2 got %b want 0100", req_ready); end
        @(negedge Clock);
        req_valid = '0;
        #1;
        tests++; if (grant_id !== 3'd2) begin fails++; $display("FAIL rst_mid_grant got %0d want 2", grant_id); end
        tests++; if (uart_message !== 8'h77) begin fails++; $display("FAIL rst_mid_msg2 got %h want 77", uart_message); end
        $display("[TB] reset_mid: regrant %0d byte %h", grant_id, uart_message);
    endtask

    task automatic test_stale_done();
        int cyc, hi, lat;
        bit early, dropped;
        do_reset();
        @(negedge Clock);
        uart_tx_done = 1'b1;
        repeat (4) @(negedge Clock);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stale_idle_busy got %b want 0", busy); end
        req_data[15:8] = 8'h9A; req_valid = 4'b0010;
        wait_ready(cyc);
        tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL stale_ready got %b want 0010", req_ready); end
        @(negedge Clock);
        req_valid = '0;
        wait_en_fall(hi);
        dropped = 1'b0;
        repeat (6) begin
            @(negedge Clock);
            if (!busy) dropped = 1'b1;
        end
        uart_tx_done = 1'b0;
        repeat (6) begin
            @(negedge Clock);
            if (!busy) dropped = 1'b1;
        end
        tests++; if (dropped !== 1'b0) begin fails++; $display("FAIL stale_early_idle got %b want 0", dropped); end
        finish_frame(early, lat);
        tests++; if (early !== 1'b0) begin fails++; $display("FAIL stale_early got %b want 0", early); end
        tests++; if (lat !== 3) begin fails++; $display("FAIL stale_idle_lat got %0d want 3", lat); end
        $display("[TB] stale_done: grant %0d completed after fresh rise/fall", grant_id);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_clamp();
        test_timeout();
        test_reset_mid();
        test_stale_done();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "time limit");
    end

endmodule
